// File: rtl/pixel_filter_seq_if.sv
// Control and RAM-side bus of the pixel filter sequencer.
// The slave modport is the sequencer; the master modport is the host/RAM side.
interface pixel_filter_seq_if #(
  parameter int ADDR_BITS = 10,
  parameter int CH_WIDTH  = 8
);
   logic                    start;
   logic [1:0]              mode;
   logic [ADDR_BITS:0]      len;
   logic [CH_WIDTH-1:0]     thr;
   logic [ADDR_BITS-1:0]    src_addr;
   logic [3*CH_WIDTH-1:0]   src_do;
   logic                    dst_we;
   logic [ADDR_BITS-1:0]    dst_addr;
   logic [3*CH_WIDTH-1:0]   dst_di;
   logic                    busy;
   logic                    done;
   logic [ADDR_BITS:0]      pix_cnt;
   logic [2:0]              state_dbg;

   modport slave (
      input  start, mode, len, thr, src_do,
      output src_addr, dst_we, dst_addr, dst_di, busy, done, pix_cnt, state_dbg
   );

   modport master (
      output start, mode, len, thr, src_do,
      input  src_addr, dst_we, dst_addr, dst_di, busy, done, pix_cnt, state_dbg
   );
endinterface

// File: rtl/pixel_filter_seq.sv
// Pixel sequencer: reads src RAM 0..len-1, filters each RGB pixel, writes dst RAM.
// Three cycles per pixel (READ, FILTER, WRITE) followed by a one-cycle DONE.
module pixel_filter_seq #(
  parameter int ADDR_BITS = 10,
  parameter int CH_WIDTH  = 8
) (
   input  logic clk,
   input  logic reset,
   pixel_filter_seq_if.slave bus
);
   localparam int PW = 3 * CH_WIDTH;
   localparam logic [ADDR_BITS:0]   MAX_LEN = {1'b1, {ADDR_BITS{1'b0}}};
   localparam logic [ADDR_BITS:0]   ONE_L   = 1;
   localparam logic [ADDR_BITS-1:0] ONE_A   = 1;
   localparam logic [CH_WIDTH+1:0]  THREE   = 3;
   localparam logic [CH_WIDTH-1:0]  CH_MAX  = {CH_WIDTH{1'b1}};

   typedef enum logic [2:0] {IDLE, READ, FILTER, WRITE, DONE} state_t;

   state_t state, state_nxt;

   logic [1:0]           mode_q;
   logic [ADDR_BITS:0]   len_q;
   logic [CH_WIDTH-1:0]  thr_q;
   logic [ADDR_BITS-1:0] idx;
   logic                 last;

   logic [ADDR_BITS-1:0] src_addr;
   logic                 dst_we;
   logic [ADDR_BITS-1:0] dst_addr;
   logic [PW-1:0]        dst_di;
   logic                 busy;
   logic                 done;
   logic [ADDR_BITS:0]   pix_cnt;

   function automatic logic [PW-1:0] apply_filter(input logic [1:0]          m,
                                                  input logic [PW-1:0]       p,
                                                  input logic [CH_WIDTH-1:0] t);
      logic [CH_WIDTH-1:0] r, g, b, y;
      logic [CH_WIDTH+1:0] sum;
      logic [PW-1:0]       res;
      r   = p[PW-1 -: CH_WIDTH];
      g   = p[2*CH_WIDTH-1 -: CH_WIDTH];
      b   = p[CH_WIDTH-1:0];
      sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
      // Exact divide by a constant; the quotient always fits in one channel.
      y   = CH_WIDTH'(sum / THREE);
      res = p;
      case (m)
         2'b00: res = p;
         2'b01: res = {y, y, y};
         2'b10: res = {CH_MAX - r, CH_MAX - g, CH_MAX - b};
         2'b11: res = (y >= t) ? {PW{1'b1}} : {PW{1'b0}};
      endcase
      return res;
   endfunction

   assign last = ({1'b0, idx} == (len_q - ONE_L));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Handshake: start is sampled only in IDLE; busy spans READ..DONE and done
   // pulses for exactly the DONE cycle, after which start is sampled again.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? DONE : READ;
         READ:    state_nxt = FILTER;
         FILTER:  state_nxt = WRITE;
         WRITE:   state_nxt = last ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status strobes come from flops decoded off the next state, so they cannot glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q   <= '0;
         len_q    <= '0;
         thr_q    <= '0;
         idx      <= '0;
         src_addr <= '0;
         dst_we   <= 1'b0;
         dst_addr <= '0;
         dst_di   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pix_cnt  <= '0;
      end else begin
         dst_we <= (state_nxt == WRITE);
         busy   <= (state_nxt != IDLE);
         done   <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mode_q  <= bus.mode;
                  thr_q   <= bus.thr;
                  len_q   <= (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
                  idx     <= '0;
                  pix_cnt <= '0;
                  if (bus.len != '0) src_addr <= '0;
               end
            end
            FILTER: begin
               dst_addr <= idx;
               dst_di   <= apply_filter(mode_q, bus.src_do, thr_q);
            end
            WRITE: begin
               pix_cnt <= pix_cnt + ONE_L;
               if (!last) begin
                  idx      <= idx + ONE_A;
                  src_addr <= idx + ONE_A;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.src_addr  = src_addr;
   assign bus.dst_we    = dst_we;
   assign bus.dst_addr  = dst_addr;
   assign bus.dst_di    = dst_di;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.pix_cnt   = pix_cnt;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_pixel_filter_seq.sv
// Bench for pixel_filter_seq: RAM models, a per-cycle reference model of the run
// timeline and expected pixels, directed cases and randomized runs.
module tb_pixel_filter_seq;
  localparam int AB   = 10;
  localparam int CW   = 8;
  localparam int NPIX = 1024;

  logic clk;
  logic reset;

  pixel_filter_seq_if #(.ADDR_BITS(AB), .CH_WIDTH(CW)) bus ();

  pixel_filter_seq #(.ADDR_BITS(AB), .CH_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- RAM models ----------------
  logic [23:0] src_mem [0:NPIX-1];
  logic [23:0] dst_mem [0:NPIX-1];
  int wr_total;
  int wr_addr0;

  always @(posedge clk) begin
    bus.src_do <= src_mem[bus.src_addr];
    if (bus.dst_we) begin
      dst_mem[bus.dst_addr] <= bus.dst_di;
      wr_total <= wr_total + 1;
      if (bus.dst_addr == '0) wr_addr0 <= wr_addr0 + 1;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_vec;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_filter(input logic [1:0] m, input logic [23:0] p,
                                             input logic [7:0] t);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = (r + g + b) / 3;
    case (m)
      2'd0:    return p;
      2'd1:    return {y[7:0], y[7:0], y[7:0]};
      2'd2:    return {8'(255 - r), 8'(255 - g), 8'(255 - b)};
      default: return (y >= int'(t)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // m_k counts cycles since the accepting edge: pixel i is read at 3i+1, written
  // at 3i+3, and done falls on 3*len+1.
  bit          m_active;
  int          m_k;
  int          m_len;
  int          m_pix;
  logic [23:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_k      = 0;
      m_pix    = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (bus.start) begin
        m_len    = (int'(bus.len) > NPIX) ? NPIX : int'(bus.len);
        m_active = 1'b1;
        m_k      = 1;
        m_pix    = 0;
        exp_q.delete();
        for (int i = 0; i < m_len; i++) exp_q.push_back(ref_filter(bus.mode, src_mem[i], bus.thr));
      end
    end else begin
      if ((m_k % 3 == 0) && m_k >= 3 && m_k <= 3 * m_len) m_pix++;
      m_k++;
      if (m_k > 3 * m_len + 1) m_active = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        e_we, e_done, e_rd;
  logic [23:0] e_px;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_dst_we",   bus.dst_we,   0);
      check("rst_busy",     bus.busy,     0);
      check("rst_done",     bus.done,     0);
      check("rst_pix_cnt",  bus.pix_cnt,  0);
      check("rst_src_addr", bus.src_addr, 0);
      check("rst_dst_addr", bus.dst_addr, 0);
      check("rst_dst_di",   bus.dst_di,   0);
    end else begin
      e_we   = m_active && m_k >= 3 && m_k <= 3 * m_len && (m_k % 3 == 0);
      e_done = m_active && (m_k == 3 * m_len + 1);
      e_rd   = m_active && (m_k % 3 == 1) && (m_k <= 3 * m_len - 2);
      check("busy",    bus.busy,    32'(m_active));
      check("done",    bus.done,    32'(e_done));
      check("dst_we",  bus.dst_we,  32'(e_we));
      check("pix_cnt", bus.pix_cnt, m_pix);
      if (e_rd) check("src_addr", bus.src_addr, (m_k - 1) / 3);
      if (e_we) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 1, 0);
        end else begin
          e_px = exp_q.pop_front();
          check("dst_di",   bus.dst_di,   e_px);
          check("dst_addr", bus.dst_addr, m_k / 3 - 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < limit);
    if (!bus.done) check("done_timeout", 0, 1);
  endtask

  // Returns the cycle (counted from the accepting edge) in which done is seen.
  task automatic run(input logic [1:0] m, input int l, input logic [7:0] t, output int cyc);
    @(negedge clk);
    bus.mode  = m;
    bus.len   = 11'(l);
    bus.thr   = t;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 3 * l + 3200) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) check("run_timeout", 0, 1);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) src_mem[i] = 24'($urandom);
  endtask

  // ---------------- main sequence ----------------
  int cyc;
  int snap;
  int snap0;
  int n;

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.len   = '0;
    bus.thr   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("pin_gray",    ref_filter(2'd1, 24'hFF0000, 8'h00), 24'h555555);
    check("pin_invert",  ref_filter(2'd2, 24'h00FF10, 8'h00), 24'hFF00EF);
    check("pin_thr_hi",  ref_filter(2'd3, 24'h808080, 8'h80), 24'hFFFFFF);
    check("pin_thr_lo",  ref_filter(2'd3, 24'h00FF10, 8'h80), 24'h000000);

    // copy, len=4
    src_mem[0] = 24'h112233; src_mem[1] = 24'h445566;
    src_mem[2] = 24'h778899; src_mem[3] = 24'hAABBCC;
    snap = wr_total;
    run(2'd0, 4, 8'h00, cyc);
    check("copy_done_cycle", cyc, 13);
    check("copy_pix_cnt", bus.pix_cnt, 4);
    check("copy_writes", wr_total - snap, 4);
    check("copy_d0", dst_mem[0], 24'h112233);
    check("copy_d3", dst_mem[3], 24'hAABBCC);

    // gray
    src_mem[0] = 24'h060606; src_mem[1] = 24'hFF0000;
    src_mem[2] = 24'hFFFFFF; src_mem[3] = 24'h010100;
    run(2'd1, 4, 8'h00, cyc);
    check("gray_d0", dst_mem[0], 24'h060606);
    check("gray_d1", dst_mem[1], 24'h555555);
    check("gray_d2", dst_mem[2], 24'hFFFFFF);
    check("gray_d3", dst_mem[3], 24'h000000);

    // invert then threshold
    src_mem[0] = 24'h00FF10; src_mem[1] = 24'h808080;
    run(2'd2, 2, 8'h80, cyc);
    check("inv_d0", dst_mem[0], 24'hFF00EF);
    check("inv_d1", dst_mem[1], 24'h7F7F7F);
    run(2'd3, 2, 8'h80, cyc);
    check("thr_d0", dst_mem[0], 24'h000000);
    check("thr_d1", dst_mem[1], 24'hFFFFFF);

    // len=0
    snap = wr_total;
    run(2'd0, 0, 8'h00, cyc);
    check("len0_done_cycle", cyc, 1);
    check("len0_pix_cnt", bus.pix_cnt, 0);
    check("len0_writes", wr_total - snap, 0);

    // full image, then an oversized length that must clamp
    fill_random(NPIX);
    snap0 = wr_addr0;
    run(2'($urandom_range(0, 3)), NPIX, 8'($urandom), cyc);
    check("full_done_cycle", cyc, 3 * NPIX + 1);
    check("full_pix_cnt", bus.pix_cnt, NPIX);
    check("full_addr0_writes", wr_addr0 - snap0, 1);
    snap = wr_total;
    snap0 = wr_addr0;
    run(2'd0, 1500, 8'h00, cyc);
    check("clamp_done_cycle", cyc, 3 * NPIX + 1);
    check("clamp_pix_cnt", bus.pix_cnt, NPIX);
    check("clamp_writes", wr_total - snap, NPIX);
    check("clamp_addr0_writes", wr_addr0 - snap0, 1);
    check("clamp_top", dst_mem[NPIX-1], src_mem[NPIX-1]);

    // start and mode disturbed mid-run
    fill_random(4);
    @(negedge clk);
    bus.mode = 2'd0; bus.len = 11'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.mode = 2'd2; bus.len = 11'd9; bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(40, cyc);
    for (int i = 0; i < 4; i++) check("midrun_copy", dst_mem[i], src_mem[i]);
    check("midrun_pix_cnt", bus.pix_cnt, 4);

    // start held high: back-to-back runs
    fill_random(3);
    snap = wr_total;
    @(negedge clk);
    bus.mode = 2'd1; bus.len = 11'd3; bus.start = 1'b1;
    wait_done(20, cyc);
    @(negedge clk);
    check("b2b_gap_idle", bus.busy, 0);
    @(negedge clk);
    check("b2b_restart", bus.busy, 1);
    bus.start = 1'b0;
    wait_done(20, cyc);
    check("b2b_writes", wr_total - snap, 6);

    // reset during the write of pixel 2
    fill_random(8);
    @(negedge clk);
    bus.mode = 2'd0; bus.len = 11'd8; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.dst_we && bus.dst_addr == 10'd2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_write2", 32'(bus.dst_we && bus.dst_addr == 10'd2), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_we", bus.dst_we, 0);
    check("rst_async_busy", bus.busy, 0);
    check("rst_async_pix", bus.pix_cnt, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    snap = wr_total;
    repeat (10) @(negedge clk);
    check("rst_no_writes", wr_total - snap, 0);
    fill_random(8);
    run(2'd0, 8, 8'h00, cyc);
    check("rst_rerun_cycle", cyc, 25);
    check("rst_rerun_pix", bus.pix_cnt, 8);
    for (int i = 0; i < 8; i++) check("rst_rerun_data", dst_mem[i], src_mem[i]);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 40);
      fill_random(n);
      run(2'($urandom_range(0, 3)), n, 8'($urandom_range(0, 255)), cyc);
      check("rand_done_cycle", cyc, 3 * n + 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("final_exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
